// File: rtl/sys_bus_pkg.sv
// Shared types and sizing helpers for the multi-host simple-system bus.
package sys_bus_pkg;

  localparam int unsigned MaxIdxW = 8;

  // One in-flight transaction: who issued it, where it went, and whether it missed every window.
  typedef struct packed {
    logic [MaxIdxW-1:0] host;
    logic [MaxIdxW-1:0] device;
    logic               decerr;
  } track_entry_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sys_bus_arb.sv
// Host arbiter: fixed priority by default, round-robin when SYS_BUS_RR_ARB_EN is defined.
module sys_bus_arb
  import sys_bus_pkg::*;
#(
  parameter  int unsigned NrHosts = 1,
  localparam int unsigned IdxW    = idx_w(NrHosts)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en,
  input  logic [NrHosts-1:0] req,
  output logic [NrHosts-1:0] gnt,
  output logic               valid,
  output logic [IdxW-1:0]    idx
);

`ifdef SYS_BUS_RR_ARB_EN
  logic [IdxW-1:0] last_q;
  int unsigned     cand;

  // NOTE: every always_comb output gets a blocking default first, so no path can infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    gnt   = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= NrHosts; i++) begin
      cand = (32'(last_q) + i) % NrHosts;
      if (en && !valid && req[IdxW'(cand)]) begin
        valid = 1'b1;
        idx   = IdxW'(cand);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

  // Reset value makes host 0 the first one searched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    last_q <= IdxW'(NrHosts - 1);
    else if (valid) last_q <= idx;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = ^{clk_i, rst_ni};

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int i = int'(NrHosts) - 1; i >= 0; i--) begin
      if (en && req[IdxW'(i)]) begin
        valid = 1'b1;
        idx   = IdxW'(i);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/sys_bus_mh.sv
// Multi-host pipelined bus with base/mask decode and in-order response tracking.
// Arbitration policy selected by SYS_BUS_RR_ARB_EN (see sys_bus_arb).
module sys_bus_mh
  import sys_bus_pkg::*;
#(
  parameter int unsigned NrDevices      = 1,
  parameter int unsigned NrHosts        = 1,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [NrHosts-1:0]      host_err_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],

  output logic [NrDevices-1:0]    device_req_o,
  output logic [NrDevices-1:0]    device_we_o,
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]    device_rvalid_i,
  input  logic [NrDevices-1:0]    device_err_i,
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base_i [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask_i [NrDevices]
);

  localparam int unsigned HostW = idx_w(NrHosts);
  localparam int unsigned DevW  = idx_w(NrDevices);
  localparam int unsigned PtrW  = idx_w(MaxOutstanding);
  localparam int unsigned CntW  = cnt_w(MaxOutstanding);

  logic                arb_valid;
  logic [HostW-1:0]    win;
  logic                fifo_full;
  logic                fifo_empty;
  logic                dec_hit;
  logic [DevW-1:0]     dec_dev;
  logic                push;
  logic                pop;
  track_entry_t        head;
  track_entry_t        new_entry;
  logic [HostW-1:0]    head_host;
  logic [DevW-1:0]     head_dev;

  track_entry_t        fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     wptr_q;
  logic [PtrW-1:0]     rptr_q;
  logic [CntW-1:0]     count_q;

  sys_bus_arb #(.NrHosts(NrHosts)) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (!fifo_full),
    .req   (host_req_i),
    .gnt   (host_gnt_o),
    .valid (arb_valid),
    .idx   (win)
  );

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_dev = '0;
    for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
      if ((host_addr_i[win] & cfg_device_addr_mask_i[DevW'(d)]) == cfg_device_addr_base_i[DevW'(d)]) begin
        dec_hit = 1'b1;
        dec_dev = DevW'(d);
      end
    end
  end

  always_comb begin
    device_req_o   = '0;
    device_we_o    = '0;
    device_addr_o  = '{default: '0};
    device_be_o    = '{default: '0};
    device_wdata_o = '{default: '0};
    if (arb_valid && dec_hit) begin
      device_req_o[dec_dev]   = 1'b1;
      device_we_o[dec_dev]    = host_we_i[win];
      device_addr_o[dec_dev]  = host_addr_i[win];
      device_be_o[dec_dev]    = host_be_i[win];
      device_wdata_o[dec_dev] = host_wdata_i[win];
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign head       = fifo_q[rptr_q];
  assign head_host  = HostW'(head.host);
  assign head_dev   = DevW'(head.device);
  assign push       = arb_valid;
  // Decode errors retire on their own as soon as they reach the head.
  assign pop        = !fifo_empty && (head.decerr || device_rvalid_i[head_dev]);

  assign new_entry = '{host: MaxIdxW'(win), device: MaxIdxW'(dec_dev), decerr: !dec_hit};

  // NOTE: entry storage has no reset; count_q gates every read, so stale contents are never seen.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= new_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '{default: '0};
    if (pop) begin
      host_rvalid_o[head_host] = 1'b1;
      if (head.decerr) begin
        host_err_o[head_host] = 1'b1;
      end else begin
        host_err_o[head_host]   = device_err_i[head_dev];
        host_rdata_o[head_host] = device_rdata_i[head_dev];
      end
    end
  end

  // Responses still in flight from before a reset may land in the first cycle after release.
  logic                 armed_q;
  logic [NrDevices-1:0] resp_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) armed_q <= 1'b0;
    else         armed_q <= 1'b1;
  end

  always_comb begin
    resp_ok = '0;
    if (!fifo_empty && !head.decerr) resp_ok[head_dev] = 1'b1;
  end

  a_resp_from_head: assert property (@(posedge clk_i) disable iff (!rst_ni || !armed_q)
    (device_rvalid_i & ~resp_ok) == '0);

endmodule

// File: tb/tb_sys_bus_mh.sv
// Directed bench for sys_bus_mh: two hosts, RAM and timer devices, two outstanding slots.
module tb_sys_bus_mh;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [31:0] host_addr [2];
  logic [3:0]  host_be [2];
  logic [31:0] host_wdata [2];
  logic [31:0] host_rdata [2];
  logic [1:0]  device_req, device_we, device_rvalid, device_err;
  logic [31:0] device_addr [2];
  logic [3:0]  device_be [2];
  logic [31:0] device_wdata [2];
  logic [31:0] device_rdata [2];
  logic [31:0] cfg_base [2];
  logic [31:0] cfg_mask [2];

  int total = 0;
  int bad   = 0;
  logic [1:0] arb_exp [4];

  always #5 clk = ~clk;

  sys_bus_mh #(
    .NrDevices(2), .NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .host_req_i            (host_req),
    .host_we_i             (host_we),
    .host_addr_i           (host_addr),
    .host_be_i             (host_be),
    .host_wdata_i          (host_wdata),
    .host_gnt_o            (host_gnt),
    .host_rvalid_o         (host_rvalid),
    .host_err_o            (host_err),
    .host_rdata_o          (host_rdata),
    .device_req_o          (device_req),
    .device_we_o           (device_we),
    .device_addr_o         (device_addr),
    .device_be_o           (device_be),
    .device_wdata_o        (device_wdata),
    .device_rvalid_i       (device_rvalid),
    .device_err_i          (device_err),
    .device_rdata_i        (device_rdata),
    .cfg_device_addr_base_i(cfg_base),
    .cfg_device_addr_mask_i(cfg_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SYS_BUS_RR_ARB_EN
    arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_ni        = 1'b0;
    host_req      = '0;
    host_we       = '0;
    host_addr     = '{default: '0};
    host_be       = '{default: '0};
    host_wdata    = '{default: '0};
    device_rvalid = '0;
    device_err    = '0;
    device_rdata  = '{default: '0};
    cfg_base      = '{32'h0010_0000, 32'h0002_0000};
    cfg_mask      = '{32'hFFF0_0000, 32'hFFFF_0000};

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", host_gnt, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_err", host_err, 0);
    check("rst_rdata0", host_rdata[0], 0);
    check("rst_rdata1", host_rdata[1], 0);
    check("rst_dreq", device_req, 0);
    rst_ni = 1'b1;
    step();

    // Single mapped read
    host_req = 2'b01; host_addr[0] = 32'h0010_0004; host_be[0] = 4'hF; #2;
    check("rd_gnt", host_gnt, 2'b01);
    check("rd_dreq", device_req, 2'b01);
    check("rd_daddr", device_addr[0], 32'h0010_0004);
    check("rd_dwe", device_we, 0);
    check("rd_no_early_rvalid", host_rvalid, 0);
    step();
    host_req = '0; device_rvalid = 2'b01; device_rdata[0] = 32'hDEAD_BEEF; #2;
    check("rd_rvalid", host_rvalid, 2'b01);
    check("rd_rdata", host_rdata[0], 32'hDEAD_BEEF);
    check("rd_err", host_err, 0);
    step();
    device_rvalid = '0;

    // Unmapped read
    host_req = 2'b01; host_addr[0] = 32'h0; #2;
    check("de_gnt", host_gnt, 2'b01);
    check("de_dreq", device_req, 0);
    check("de_no_early_rvalid", host_rvalid, 0);
    step();
    host_req = '0; #2;
    check("de_rvalid", host_rvalid, 2'b01);
    check("de_err", host_err, 2'b01);
    check("de_rdata", host_rdata[0], 0);
    step();

    // Fill the tracker: third request waits for a pop
    host_req = 2'b01; host_we = 2'b01; host_addr[0] = 32'h0010_0000;
    host_wdata[0] = 32'h55AA_55AA; host_be[0] = 4'h3; #2;
    check("full_gnt1", host_gnt, 2'b01);
    check("full_dwe", device_we, 2'b01);
    check("full_dwdata", device_wdata[0], 32'h55AA_55AA);
    check("full_dbe", device_be[0], 4'h3);
    step(); #2;
    check("full_gnt2", host_gnt, 2'b01);
    step(); #2;
    check("full_gnt3_held", host_gnt, 0);
    check("full_dreq_held", device_req, 0);
    step();
    device_rvalid = 2'b01; device_rdata[0] = 32'h0; #2;
    check("full_pop_no_gnt", host_gnt, 0);
    check("full_pop_rvalid", host_rvalid, 2'b01);
    step();
    device_rvalid = '0; #2;
    check("full_gnt3", host_gnt, 2'b01);
    step();
    host_req = '0; host_we = '0; device_rvalid = 2'b01; #2;
    check("full_drain1", host_rvalid, 2'b01);
    step(); #2;
    check("full_drain2", host_rvalid, 2'b01);
    step();
    device_rvalid = '0; #2;
    check("full_empty", host_rvalid, 0);

    // Mixed: RAM read (h0), decode error (h1), timer read (h0)
    host_req = 2'b01; host_addr[0] = 32'h0010_0008; #2;
    check("mix_gnt_ram", host_gnt, 2'b01);
    step();
    host_req = 2'b10; host_addr[1] = 32'h0; #2;
    check("mix_gnt_de", host_gnt, 2'b10);
    check("mix_dreq_de", device_req, 0);
    check("mix_no_rvalid", host_rvalid, 0);
    step();
    host_req = 2'b01; host_addr[0] = 32'h0002_0010;
    device_rvalid = 2'b01; device_rdata[0] = 32'h1111_2222; #2;
    check("mix_tmr_held", host_gnt, 0);
    check("mix_ram_rvalid", host_rvalid, 2'b01);
    check("mix_ram_rdata", host_rdata[0], 32'h1111_2222);
    step();
    device_rvalid = '0; #2;
    check("mix_gnt_tmr", host_gnt, 2'b01);
    check("mix_dreq_tmr", device_req, 2'b10);
    check("mix_daddr_tmr", device_addr[1], 32'h0002_0010);
    check("mix_de_rvalid", host_rvalid, 2'b10);
    check("mix_de_err", host_err, 2'b10);
    check("mix_de_rdata", host_rdata[1], 0);
    step();
    host_req = '0; device_rvalid = 2'b10; device_rdata[1] = 32'hCAFE_0001; device_err = 2'b10; #2;
    check("mix_tmr_rvalid", host_rvalid, 2'b01);
    check("mix_tmr_err", host_err, 2'b01);
    check("mix_tmr_rdata", host_rdata[0], 32'hCAFE_0001);
    step();
    device_rvalid = '0; device_err = '0;

    // Reset with two outstanding, stale response right after release
    host_req = 2'b01; host_addr[0] = 32'h0010_0000;
    step();
    step(); #2;
    check("rst2_full", host_gnt, 0);
    host_req = '0; rst_ni = 1'b0;
    step();
    check("rst2_rvalid_in_rst", host_rvalid, 0);
    rst_ni = 1'b1; device_rvalid = 2'b01; device_rdata[0] = 32'h0000_0BAD; #2;
    check("rst2_stale_ignored", host_rvalid, 0);
    step();
    device_rvalid = '0;

    // Arbitration with both hosts requesting every cycle
    host_req = 2'b11; host_addr[0] = 32'h0010_0000; host_addr[1] = 32'h0010_0000; #2;
    check("arb_gnt0", host_gnt, arb_exp[0]);
    step();
    device_rvalid = 2'b01; device_rdata[0] = 32'h0000_00A0; #2;
    check("arb_gnt1", host_gnt, arb_exp[1]);
    check("arb_rv0", host_rvalid, arb_exp[0]);
    step(); #2;
    check("arb_gnt2", host_gnt, arb_exp[2]);
    check("arb_rv1", host_rvalid, arb_exp[1]);
    step(); #2;
    check("arb_gnt3", host_gnt, arb_exp[3]);
    check("arb_rv2", host_rvalid, arb_exp[2]);
    step();
    host_req = '0; #2;
    check("arb_rv3", host_rvalid, arb_exp[3]);
    step();
    device_rvalid = '0; #2;
    check("arb_idle_rvalid", host_rvalid, 0);
    check("arb_idle_gnt", host_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
